// File: rtl/ram32_wb_responder.sv
// Wishbone-classic responder putting the RAM32 macro behind SERV ibus/dbus.
// Define RAM32_WB_FASTREAD_EN for the 3-state FSM with combinational rdt.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_ibus_cyc/adr        fetch request and byte address
//   o_ibus_rdt/ack        fetch data, one-cycle ack
//   i_dbus_cyc/adr/we     data request, byte address, write enable
//   i_dbus_dat/sel        write data, byte enables
//   o_dbus_rdt/ack        read data, one-cycle ack
//   o_ram_en/a/we/di      RAM EN0/A0/WE0/Di0
//   i_ram_do              RAM Do0, valid the cycle after an enabled edge

module ram32_wb_responder #(
  parameter int ADDR_W     = 5,
  parameter bit DBUS_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ibus_cyc,
  input  logic [31:0]       i_ibus_adr,
  output logic [31:0]       o_ibus_rdt,
  output logic              o_ibus_ack,
  input  logic              i_dbus_cyc,
  input  logic [31:0]       i_dbus_adr,
  input  logic              i_dbus_we,
  input  logic [31:0]       i_dbus_dat,
  input  logic [3:0]        i_dbus_sel,
  output logic [31:0]       o_dbus_rdt,
  output logic              o_dbus_ack,
  output logic              o_ram_en,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic [3:0]        o_ram_we,
  output logic [31:0]       o_ram_di,
  input  logic [31:0]       i_ram_do
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    ACK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              req;
  logic              pick_d;
  logic [31:0]       adr;
  logic              g_dbus;
  logic              g_we;
  logic              g_inr;
  logic [ADDR_W-1:0] g_adr;
  logic [3:0]        g_sel;
  logic [31:0]       g_dat;
  logic              rd_ok;
  logic              unused_adr;

  assign req    = i_ibus_cyc | i_dbus_cyc;
  assign pick_d = i_dbus_cyc & (DBUS_FIRST | ~i_ibus_cyc);
  assign adr    = pick_d ? i_dbus_adr : i_ibus_adr;
  // byte offset within the word is irrelevant to a word RAM
  assign unused_adr = ^adr[1:0];
  assign rd_ok  = ~g_we & g_inr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req) state_nxt = ACCESS;
      end
`ifdef RAM32_WB_FASTREAD_EN
      ACCESS:  state_nxt = ACK;
      CAPTURE: state_nxt = IDLE;
`else
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
`endif
      ACK:     state_nxt = IDLE;
    endcase
  end

  // The loser of a conflict is not remembered: it keeps cyc high and
  // simply wins the next IDLE sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_dbus <= 1'b0;
      g_adr  <= '0;
      g_we   <= 1'b0;
      g_sel  <= '0;
      g_dat  <= '0;
      g_inr  <= 1'b0;
    end else if (state == IDLE && req) begin
      g_dbus <= pick_d;
      g_adr  <= adr[ADDR_W+1:2];
      g_we   <= pick_d & i_dbus_we;
      g_sel  <= i_dbus_sel;
      g_dat  <= i_dbus_dat;
      g_inr  <= (adr[31:ADDR_W+2] == '0);
    end
  end

  // Gated by rst_n so a reset asserted during ACCESS blocks the write.
  always_comb begin
    o_ram_en = 1'b0;
    o_ram_a  = '0;
    o_ram_we = '0;
    o_ram_di = '0;
    if (rst_n && state == ACCESS) begin
      o_ram_en = g_inr;
      o_ram_a  = g_adr;
      o_ram_we = (g_we && g_inr) ? g_sel : 4'h0;
      o_ram_di = g_dat;
    end
  end

  assign o_dbus_ack = rst_n & (state == ACK) & g_dbus;
  assign o_ibus_ack = rst_n & (state == ACK) & ~g_dbus;

`ifdef RAM32_WB_FASTREAD_EN
  always_comb begin
    o_dbus_rdt = '0;
    o_ibus_rdt = '0;
    if (rst_n && state == ACK && rd_ok) begin
      if (g_dbus) o_dbus_rdt = i_ram_do;
      else        o_ibus_rdt = i_ram_do;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_dbus_rdt <= '0;
      o_ibus_rdt <= '0;
    end else if (state == CAPTURE) begin
      if (g_dbus) o_dbus_rdt <= rd_ok ? i_ram_do : 32'h0;
      else        o_ibus_rdt <= rd_ok ? i_ram_do : 32'h0;
    end
  end
`endif

endmodule

// File: tb/tb_ram32_wb_responder.sv
// Directed self-checking bench for ram32_wb_responder.
// Carries a behavioural RAM32 model on the RAM port.

module tb_ram32_wb_responder;

`ifdef RAM32_WB_FASTREAD_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  localparam int GAP = LAT + 1;

  logic        clk;
  logic        rst_n;
  logic        i_ibus_cyc;
  logic [31:0] i_ibus_adr;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        i_dbus_cyc;
  logic [31:0] i_dbus_adr;
  logic        i_dbus_we;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        o_ram_en;
  logic [4:0]  o_ram_a;
  logic [3:0]  o_ram_we;
  logic [31:0] o_ram_di;
  logic [31:0] ram_do;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem [32];

  bit         en_seen;
  bit         we_seen;
  logic [3:0] we_last;
  logic [4:0] a_last;
  int         d_acks;
  int         i_acks;
  bit         both_seen;

  ram32_wb_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ibus_cyc (i_ibus_cyc),
    .i_ibus_adr (i_ibus_adr),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_cyc (i_dbus_cyc),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_dat (i_dbus_dat),
    .i_dbus_sel (i_dbus_sel),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .o_ram_en   (o_ram_en),
    .o_ram_a    (o_ram_a),
    .o_ram_we   (o_ram_we),
    .o_ram_di   (o_ram_di),
    .i_ram_do   (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (o_ram_we[b]) mem[o_ram_a][8*b +: 8] <= o_ram_di[8*b +: 8];
      end
      ram_do <= mem[o_ram_a];
    end
  end

  always @(negedge clk) begin
    if (o_ram_en) begin
      en_seen = 1'b1;
      a_last  = o_ram_a;
    end
    if (o_ram_we != 4'h0) begin
      we_seen = 1'b1;
      we_last = o_ram_we;
    end
    if (o_dbus_ack) d_acks++;
    if (o_ibus_ack) i_acks++;
    if (o_dbus_ack && o_ibus_ack) both_seen = 1'b1;
  end

  task automatic clear_mon();
    en_seen   = 1'b0;
    we_seen   = 1'b0;
    we_last   = 4'h0;
    a_last    = 5'h0;
    d_acks    = 0;
    i_acks    = 0;
    both_seen = 1'b0;
  endtask

  // One transaction; lat = posedges from the sampling edge to ack, -1 on timeout.
  task automatic xfer(input bit ib, input logic [31:0] adr,
                      input bit we, input logic [31:0] dat,
                      input logic [3:0] sel,
                      output logic [31:0] rdt, output int lat);
    @(negedge clk);
    if (ib) begin
      i_ibus_cyc = 1'b1;
      i_ibus_adr = adr;
    end else begin
      i_dbus_cyc = 1'b1;
      i_dbus_adr = adr;
      i_dbus_we  = we;
      i_dbus_dat = dat;
      i_dbus_sel = sel;
    end
    lat = -1;
    rdt = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ib ? o_ibus_ack : o_dbus_ack) begin
        lat = n;
        rdt = ib ? o_ibus_rdt : o_dbus_rdt;
        break;
      end
    end
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    i_dbus_we  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lat;
    rst_n      = 1'b0;
    i_ibus_cyc = 1'b1;
    i_dbus_cyc = 1'b1;
    i_ibus_adr = 32'h0;
    i_dbus_adr = 32'h0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if ({o_ibus_ack, o_dbus_ack, o_ram_en} !== 3'b000) begin
        fails++;
        $display("FAIL reset_ctl: got %b, expected 000",
                 {o_ibus_ack, o_dbus_ack, o_ram_en});
      end
      checks++;
      if ({o_ibus_rdt, o_dbus_rdt} !== 64'h0) begin
        fails++;
        $display("FAIL reset_rdt: got %h/%h, expected 0",
                 o_ibus_rdt, o_dbus_rdt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (o_ibus_ack || o_dbus_ack) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL reset_first_ack_lat: got %0d, expected %0d", lat, LAT);
    end
    checks++;
    if ({o_dbus_ack, o_ibus_ack} !== 2'b10) begin
      fails++;
      $display("FAIL reset_first_owner: got %b, expected 10",
               {o_dbus_ack, o_ibus_ack});
    end
    checks++;
    if (o_dbus_rdt !== 32'h13) begin
      fails++;
      $display("FAIL reset_first_rdt: got %h, expected 00000013", o_dbus_rdt);
    end
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rdt;
    int lat;
    clear_mon();
    xfer(1'b0, 32'h14, 1'b1, 32'hDEADBEEF, 4'hF, rdt, lat);
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL wr_lat: got %0d, expected %0d", lat, LAT);
    end
    checks++;
    if (a_last !== 5'd5) begin
      fails++;
      $display("FAIL wr_ram_a: got %0d, expected 5", a_last);
    end
    checks++;
    if (we_last !== 4'hF) begin
      fails++;
      $display("FAIL wr_ram_we: got %h, expected f", we_last);
    end
    checks++;
    if (d_acks !== 1 || i_acks !== 0) begin
      fails++;
      $display("FAIL wr_ack_cnt: got d=%0d i=%0d, expected d=1 i=0",
               d_acks, i_acks);
    end
    checks++;
    if (rdt !== 32'h0) begin
      fails++;
      $display("FAIL wr_rdt: got %h, expected 0", rdt);
    end
    clear_mon();
    xfer(1'b0, 32'h14, 1'b0, 32'h0, 4'hF, rdt, lat);
    checks++;
    if (rdt !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_data: got %h, expected deadbeef", rdt);
    end
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL rd_lat: got %0d, expected %0d", lat, LAT);
    end
    checks++;
    if (we_seen !== 1'b0) begin
      fails++;
      $display("FAIL rd_no_we: got %b, expected 0", we_seen);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rdt;
    int lat;
    clear_mon();
    xfer(1'b0, 32'h14, 1'b1, 32'h00AA0000, 4'h4, rdt, lat);
    checks++;
    if (we_last !== 4'h4) begin
      fails++;
      $display("FAIL bw_ram_we: got %h, expected 4", we_last);
    end
    xfer(1'b0, 32'h14, 1'b0, 32'h0, 4'hF, rdt, lat);
    checks++;
    if (rdt !== 32'hDEAABEEF) begin
      fails++;
      $display("FAIL bw_data: got %h, expected deaabeef", rdt);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rdt;
    int lat;
    clear_mon();
    @(negedge clk);
    i_dbus_cyc = 1'b1;
    i_dbus_adr = 32'h14;
    i_dbus_we  = 1'b1;
    i_dbus_dat = 32'h0;
    i_dbus_sel = 4'hF;
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    i_dbus_cyc = 1'b0;
    i_dbus_we  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_dbus_rdt !== 32'h0) begin
      fails++;
      $display("FAIL abort_rdt: got %h, expected 0", o_dbus_rdt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (d_acks !== 0) begin
      fails++;
      $display("FAIL abort_no_ack: got %0d acks, expected 0", d_acks);
    end
    xfer(1'b0, 32'h14, 1'b0, 32'h0, 4'hF, rdt, lat);
    checks++;
    if (rdt !== 32'hDEAABEEF) begin
      fails++;
      $display("FAIL abort_no_write: got %h, expected deaabeef", rdt);
    end
  endtask

  task automatic test_ibus_fetch();
    logic [31:0] rdt;
    int lat;
    clear_mon();
    i_dbus_we  = 1'b1;
    i_dbus_dat = 32'hFFFFFFFF;
    i_dbus_sel = 4'hF;
    xfer(1'b1, 32'h0, 1'b0, 32'h0, 4'h0, rdt, lat);
    checks++;
    if (rdt !== 32'h13) begin
      fails++;
      $display("FAIL fetch_data: got %h, expected 00000013", rdt);
    end
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL fetch_lat: got %0d, expected %0d", lat, LAT);
    end
    checks++;
    if (i_acks !== 1 || d_acks !== 0) begin
      fails++;
      $display("FAIL fetch_ack_cnt: got i=%0d d=%0d, expected i=1 d=0",
               i_acks, d_acks);
    end
    checks++;
    if (we_seen !== 1'b0) begin
      fails++;
      $display("FAIL fetch_no_we: got %b, expected 0", we_seen);
    end
  endtask

  task automatic test_conflict();
    int dl;
    int il;
    logic [31:0] drd;
    logic [31:0] ird;
    clear_mon();
    @(negedge clk);
    i_dbus_cyc = 1'b1;
    i_dbus_adr = 32'h14;
    i_dbus_we  = 1'b0;
    i_ibus_cyc = 1'b1;
    i_ibus_adr = 32'h0;
    dl  = -1;
    il  = -1;
    drd = 'x;
    ird = 'x;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (o_dbus_ack && dl < 0) begin
        dl = n;
        drd = o_dbus_rdt;
        i_dbus_cyc = 1'b0;
      end
      if (o_ibus_ack && il < 0) begin
        il = n;
        ird = o_ibus_rdt;
        i_ibus_cyc = 1'b0;
      end
      if (dl > 0 && il > 0) break;
    end
    i_dbus_cyc = 1'b0;
    i_ibus_cyc = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dl !== LAT) begin
      fails++;
      $display("FAIL conf_dbus_lat: got %0d, expected %0d", dl, LAT);
    end
    checks++;
    if (il !== LAT + GAP) begin
      fails++;
      $display("FAIL conf_ibus_lat: got %0d, expected %0d", il, LAT + GAP);
    end
    checks++;
    if (both_seen !== 1'b0) begin
      fails++;
      $display("FAIL conf_both_ack: got %b, expected 0", both_seen);
    end
    checks++;
    if (drd !== 32'hDEAABEEF || ird !== 32'h13) begin
      fails++;
      $display("FAIL conf_data: got %h/%h, expected deaabeef/00000013",
               drd, ird);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rdt;
    int lat;
    clear_mon();
    xfer(1'b0, 32'h80, 1'b0, 32'h0, 4'hF, rdt, lat);
    checks++;
    if (rdt !== 32'h0) begin
      fails++;
      $display("FAIL oor_rd_data: got %h, expected 0", rdt);
    end
    checks++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL oor_rd_lat: got %0d, expected %0d", lat, LAT);
    end
    checks++;
    if (en_seen !== 1'b0) begin
      fails++;
      $display("FAIL oor_rd_en: got %b, expected 0", en_seen);
    end
    clear_mon();
    xfer(1'b0, 32'h80, 1'b1, 32'hFFFFFFFF, 4'hF, rdt, lat);
    checks++;
    if (en_seen !== 1'b0 || we_seen !== 1'b0) begin
      fails++;
      $display("FAIL oor_wr_en: got en=%b we=%b, expected 0 0",
               en_seen, we_seen);
    end
    checks++;
    if (lat !== LAT || d_acks !== 1) begin
      fails++;
      $display("FAIL oor_wr_ack: got lat=%0d acks=%0d, expected %0d 1",
               lat, d_acks, LAT);
    end
    xfer(1'b0, 32'h0, 1'b0, 32'h0, 4'hF, rdt, lat);
    checks++;
    if (rdt !== 32'h13) begin
      fails++;
      $display("FAIL oor_word0_kept: got %h, expected 00000013", rdt);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0]     = 32'h00000013;
    ram_do     = 32'h0;
    rst_n      = 1'b0;
    i_ibus_cyc = 1'b0;
    i_ibus_adr = 32'h0;
    i_dbus_cyc = 1'b0;
    i_dbus_adr = 32'h0;
    i_dbus_we  = 1'b0;
    i_dbus_dat = 32'h0;
    i_dbus_sel = 4'h0;
    clear_mon();
    test_reset();
    test_write_read();
    test_byte_write();
    test_reset_abort();
    test_ibus_fetch();
    test_conflict();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
